lc3x_muldiv_unit: RTL and testbench

LC3X_MULDIV_UNIT -- requirements
Module: lc3x_muldiv_unit

---
 rtl/lc3b_types.sv | 12 +
 rtl/lc3x_muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_lc3x_muldiv_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and multiply/divide unit states.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } lc3x_muldiv_state_t;

endpackage

// File: rtl/lc3x_muldiv_unit.sv
// Iterative multiply (shift-add) and signed divide (restoring) unit.
// Holds the pipeline via stall while an operation is in flight.
module lc3x_muldiv_unit
    import lc3b_types::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             div_zero,
    output logic             stall
);

    localparam int CW = $clog2(ITER + 1);

    lc3x_muldiv_state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             op_q;
    logic             neg_q;
    logic [WIDTH-1:0] work_a;
    logic [WIDTH-1:0] work_b;
    logic [WIDTH-1:0] acc;

    logic             accept;
    logic             div0;
    logic             last_iter;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] work_a_nxt;
    logic [WIDTH-1:0] work_b_nxt;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] fin_res;

    assign accept    = (state == IDLE) && start;
    assign div0      = op && (b == '0);
    assign last_iter = (state == CALC) && (cnt == CW'(ITER - 1));
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_nxt = div0 ? DONE : CALC;
                end
            end
            CALC: begin
                stall = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        mag_a      = a[WIDTH-1] ? -a : a;
        mag_b      = b[WIDTH-1] ? -b : b;
        shifted    = {acc, work_a[WIDTH-1]};
        trial      = shifted - {1'b0, work_b};
        work_a_nxt = work_a;
        work_b_nxt = work_b;
        acc_nxt    = acc;
        fin_res    = '0;
        if (op_q) begin
            // Borrow out of the trial subtraction means the divisor did not fit.
            if (!trial[WIDTH]) begin
                acc_nxt    = trial[WIDTH-1:0];
                work_a_nxt = {work_a[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt    = shifted[WIDTH-1:0];
                work_a_nxt = {work_a[WIDTH-2:0], 1'b0};
            end
            fin_res = neg_q ? -work_a_nxt : work_a_nxt;
        end else begin
            acc_nxt    = work_b[0] ? acc + work_a : acc;
            work_a_nxt = work_a << 1;
            work_b_nxt = work_b >> 1;
            fin_res    = acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            op_q     <= 1'b0;
            neg_q    <= 1'b0;
            work_a   <= '0;
            work_b   <= '0;
            acc      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            op_q     <= op;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            work_a   <= op ? mag_a : a;
            work_b   <= op ? mag_b : b;
            acc      <= '0;
            div_zero <= div0;
            if (div0) begin
                result <= '1;
            end
        end else if (state == CALC) begin
            cnt    <= cnt + CW'(1);
            work_a <= work_a_nxt;
            work_b <= work_b_nxt;
            acc    <= acc_nxt;
            if (last_iter) begin
                result <= fin_res;
            end
        end
    end

endmodule

// File: tb/tb_lc3x_muldiv_unit.sv
// Directed bench for lc3x_muldiv_unit with a reference model and cycle checker.
module tb_lc3x_muldiv_unit;

    localparam int W  = 16;
    localparam int IT = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start = 1'b0;
    logic         op_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic [W-1:0] result;
    logic         done;
    logic         div_zero;
    logic         stall;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    bit           m_busy  = 1'b0;
    int           m_due   = 0;
    logic [W-1:0] m_new   = '0;
    bit           m_newdz = 1'b0;
    logic [W-1:0] m_res   = '0;
    bit           m_dz    = 1'b0;

    lc3x_muldiv_unit #(.WIDTH(W), .ITER(IT)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op_i),
        .a        (a_i),
        .b        (b_i),
        .result   (result),
        .done     (done),
        .div_zero (div_zero),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_op(input bit o, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        int sx;
        int sy;
        int p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!o) begin
            p = int'(x) * int'(y);
            return p[W-1:0];
        end
        if (y == '0) return '1;
        if (sx == -32768 && sy == -1) return 16'h8000;
        p = sx / sy;
        return p[W-1:0];
    endfunction

    always @(negedge reset_n) begin
        m_busy = 1'b0;
        m_res  = '0;
        m_dz   = 1'b0;
    end

    always @(posedge clk) begin
        if (reset_n) begin
            if (m_busy) begin
                if (n == m_due) begin
                    m_busy = 1'b0;
                    m_res  = m_new;
                    m_dz   = m_newdz;
                end
            end else if (start) begin
                m_busy  = 1'b1;
                m_newdz = op_i && (b_i == '0);
                m_due   = n + (m_newdz ? 1 : IT + 1);
                m_new   = ref_op(op_i, a_i, b_i);
            end
        end
        n = n + 1;
    end

    always @(negedge clk) begin
        logic exp_done;
        logic exp_stall;
        exp_done  = m_busy && (n == m_due);
        exp_stall = m_busy ? (n < m_due) : start;
        total++;
        if (done !== exp_done) begin
            bad++;
            $display("FAIL done@%0d got=%b exp=%b", n, done, exp_done);
        end
        total++;
        if (stall !== exp_stall) begin
            bad++;
            $display("FAIL stall@%0d got=%b exp=%b", n, stall, exp_stall);
        end
        if (exp_done || !m_busy) begin
            total++;
            if (result !== (exp_done ? m_new : m_res) ||
                div_zero !== (exp_done ? m_newdz : m_dz)) begin
                bad++;
                $display("FAIL result@%0d got=%h/%b exp=%h/%b", n, result, div_zero,
                         exp_done ? m_new : m_res, exp_done ? m_newdz : m_dz);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input bit o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er,
                          input bit edz, input int elat);
        int  n_s;
        bit  got;
        got = 1'b0;
        @(posedge clk);
        #2;
        start = 1'b1;
        op_i  = o;
        a_i   = x;
        b_i   = y;
        n_s   = n;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                check({name, "_res"}, int'(result), int'(er));
                check({name, "_dz"}, int'(div_zero), int'(edz));
                check({name, "_lat"}, n - n_s, elat);
            end else if (k == 3) begin
                a_i  = ~a_i;
                b_i  = b_i + 16'd5;
                op_i = ~op_i;
            end
        end
        if (!got) check({name, "_timeout"}, 0, 1);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic run_b2b();
        int  n1;
        int  n2;
        int  cnt;
        n1  = 0;
        n2  = 0;
        cnt = 0;
        @(posedge clk);
        #2;
        start = 1'b1;
        op_i  = 1'b0;
        a_i   = 16'd3;
        b_i   = 16'd5;
        for (int k = 0; k < 80 && cnt < 2; k++) begin
            @(negedge clk);
            if (done) begin
                cnt++;
                if (cnt == 1) begin
                    n1 = n;
                    check("b2b_first", int'(result), 15);
                    a_i = 16'd10;
                    b_i = 16'd11;
                end else begin
                    n2 = n;
                    check("b2b_second", int'(result), 110);
                end
            end
        end
        check("b2b_pulses", cnt, 2);
        check("b2b_gap", n2 - n1, 18);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_result", int'(result), 0);
        check("rst_done", int'(done), 0);
        check("rst_dz", int'(div_zero), 0);
        check("rst_stall", int'(stall), 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;

        check("model_pin_div", int'(ref_op(1'b1, 16'hFFF9, 16'd2)), 16'hFFFD);
        check("model_pin_ovf", int'(ref_op(1'b1, 16'h8000, 16'hFFFF)), 16'h8000);

        run_op("mul_7x6",   1'b0, 16'd7,    16'd6,    16'd42,   1'b0, 17);
        run_op("mul_m1x3",  1'b0, 16'hFFFF, 16'd3,    16'hFFFD, 1'b0, 17);
        run_op("div_m7d2",  1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 1'b0, 17);
        run_op("div_ovf",   1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 17);
        run_op("div_5d0",   1'b1, 16'd5,    16'd0,    16'hFFFF, 1'b1, 1);
        run_op("div_9d3",   1'b1, 16'd9,    16'd3,    16'd3,    1'b0, 17);
        run_op("div_100dm7", 1'b1, 16'd100, 16'hFFF9, 16'hFFF2, 1'b0, 17);
        run_op("mul_big",   1'b0, 16'h1234, 16'h0100, 16'h3400, 1'b0, 17);

        @(posedge clk);
        #2;
        start = 1'b1;
        op_i  = 1'b0;
        a_i   = 16'd100;
        b_i   = 16'd3;
        repeat (8) @(posedge clk);
        #2;
        start   = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_result", int'(result), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_stall", int'(stall), 0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        run_op("mul_4x4", 1'b0, 16'd4, 16'd4, 16'd16, 1'b0, 17);
        run_b2b();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
